// File: rtl/omer_pkg.sv
// ---------------------------------------------------------------------------
// omer_pkg
// Shared types and encoding constants for the kamus decode queue.
// Contents:
//   operation_e     : decoded operation, INVALID marks an illegal instruction
//   instr_decoded_t : raw register/function fields of an instruction
//   csr_e           : CSR addresses the decoder knows about
//   imm_fmt_e       : immediate format selector
//   OPC_* / F3_* / F12_* : opcode, funct3 and funct12 encodings
//   csr_supported() : whether a CSR address is implemented
// ---------------------------------------------------------------------------
package omer_pkg;

  typedef enum logic [5:0] {
    INVALID,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I,
    ECALL, EBREAK, MRET, WFI,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } operation_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] func3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] func7;
  } instr_decoded_t;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MCYCLEH   = 12'hB80,
    CSR_CYCLE     = 12'hC00,
    CSR_TIME      = 12'hC01,
    CSR_CYCLEH    = 12'hC80,
    CSR_TIMEH     = 12'hC81,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } csr_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_NONE
  } imm_fmt_e;

  // Major opcodes (bits [1:0] = 2'b11 are part of every legal opcode)
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_RSVD   = 3'b100;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_WFI    = 12'h105;
  localparam logic [11:0] F12_MRET   = 12'h302;

  // User counters are always present; the machine set only with machine mode.
  function automatic logic csr_supported(input logic [11:0] addr,
                                         input logic        machine_mode);
    logic ok;
    ok = 1'b0;
    case (addr)
      CSR_CYCLE, CSR_TIME, CSR_CYCLEH, CSR_TIMEH:
        ok = 1'b1;
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID:
        ok = machine_mode;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/kamus_decoder.sv
// ---------------------------------------------------------------------------
// kamus_decoder
// Purely combinational RV32I/RV64I base decoder.
// Ports:
//   instr_i     : raw 32-bit instruction
//   operation_o : decoded operation (INVALID when illegal)
//   fields_o    : opcode/rd/func3/rs1/rs2/func7 slices
//   imm_o       : XLEN-wide immediate, sign-extended from instr[31]
//                 (CSR ops carry the zero-extended rs1 field as uimm)
//   illegal_o   : operation_o == INVALID
// ---------------------------------------------------------------------------
import omer_pkg::*;

module kamus_decoder #(
  parameter int XLEN         = 32,
  parameter int MACHINE_MODE = 1
) (
  input  logic [31:0]      instr_i,
  output operation_e       operation_o,
  output instr_decoded_t   fields_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             illegal_o
);

  localparam logic IS64 = (XLEN == 64);
  localparam logic MM   = (MACHINE_MODE != 0);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] funct12;
  imm_fmt_e    fmt;
  logic        csr_write;
  logic        shift_ok;
  logic [31:0] imm32;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign rs1     = instr_i[19:15];
  assign funct7  = instr_i[31:25];
  assign funct12 = instr_i[31:20];

  always_comb begin
    fields_o        = '0;
    fields_o.opcode = opcode;
    fields_o.rd     = rd;
    fields_o.func3  = funct3;
    fields_o.rs1    = rs1;
    fields_o.rs2    = instr_i[24:20];
    fields_o.func7  = funct7;
  end

  // Immediate shifts: shamt is 5 bits on RV32, so instr[25] must be clear
  // there; instr[30] selects arithmetic right shift and is checked per-op.
  assign shift_ok = (instr_i[31] == 1'b0) && (instr_i[29:26] == 4'b0000) &&
                    (IS64 || !instr_i[25]);

  always_comb begin
    operation_o = INVALID;
    fmt         = IMM_NONE;
    // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero source
    csr_write   = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
    case (opcode)
      OPC_LUI:   begin operation_o = LUI;   fmt = IMM_U; end
      OPC_AUIPC: begin operation_o = AUIPC; fmt = IMM_U; end
      OPC_JAL:   begin operation_o = JAL;   fmt = IMM_J; end
      OPC_JALR: begin
        fmt = IMM_I;
        if (funct3 == 3'b000) operation_o = JALR;
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        case (funct3)
          F3_BEQ:  operation_o = BEQ;
          F3_BNE:  operation_o = BNE;
          F3_BLT:  operation_o = BLT;
          F3_BGE:  operation_o = BGE;
          F3_BLTU: operation_o = BLTU;
          F3_BGEU: operation_o = BGEU;
          default: operation_o = INVALID;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I;
        case (funct3)
          F3_LB:   operation_o = LB;
          F3_LH:   operation_o = LH;
          F3_LW:   operation_o = LW;
          F3_LBU:  operation_o = LBU;
          F3_LHU:  operation_o = LHU;
          F3_LD:   operation_o = IS64 ? LD : INVALID;
          F3_LWU:  operation_o = IS64 ? LWU : INVALID;
          default: operation_o = INVALID;
        endcase
      end
      OPC_STORE: begin
        fmt = IMM_S;
        case (funct3)
          F3_SB:   operation_o = SB;
          F3_SH:   operation_o = SH;
          F3_SW:   operation_o = SW;
          F3_SD:   operation_o = IS64 ? SD : INVALID;
          default: operation_o = INVALID;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = IMM_I;
        case (funct3)
          F3_ADD:  operation_o = ADD;   // no SUBI: instr[30] is immediate data here
          F3_SLT:  operation_o = SLT;
          F3_SLTU: operation_o = SLTU;
          F3_XOR:  operation_o = XOR;
          F3_OR:   operation_o = OR;
          F3_AND:  operation_o = AND;
          F3_SLL:  operation_o = (shift_ok && !instr_i[30]) ? SLL : INVALID;
          F3_SRL:  operation_o = !shift_ok ? INVALID : (instr_i[30] ? SRA : SRL);
          default: operation_o = INVALID;
        endcase
      end
      OPC_OP: begin
        fmt = IMM_NONE;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            F3_ADD:  operation_o = ADD;
            F3_SLL:  operation_o = SLL;
            F3_SLT:  operation_o = SLT;
            F3_SLTU: operation_o = SLTU;
            F3_XOR:  operation_o = XOR;
            F3_SRL:  operation_o = SRL;
            F3_OR:   operation_o = OR;
            F3_AND:  operation_o = AND;
            default: operation_o = INVALID;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            F3_ADD:  operation_o = SUB;
            F3_SRL:  operation_o = SRA;
            default: operation_o = INVALID;
          endcase
        end
      end
      OPC_MISC_MEM: begin
        fmt = IMM_NONE;
        if (funct3[2:1] == 2'b00) operation_o = funct3[0] ? FENCE_I : FENCE;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_PRIV) begin
          fmt = IMM_NONE;
          if ((rd == 5'd0) && (rs1 == 5'd0)) begin
            case (funct12)
              F12_ECALL:  operation_o = ECALL;
              F12_EBREAK: operation_o = EBREAK;
              F12_MRET:   operation_o = MM ? MRET : INVALID;
              F12_WFI:    operation_o = MM ? WFI : INVALID;
              default:    operation_o = INVALID;
            endcase
          end
        end else if (funct3 != F3_RSVD) begin
          fmt = IMM_Z;
          // csr[11:10] == 2'b11 marks a read-only CSR
          if (csr_supported(funct12, MM) &&
              !(csr_write && (funct12[11:10] == 2'b11))) begin
            case (funct3)
              F3_CSRRW:  operation_o = CSRRW;
              F3_CSRRS:  operation_o = CSRRS;
              F3_CSRRC:  operation_o = CSRRC;
              F3_CSRRWI: operation_o = CSRRWI;
              F3_CSRRSI: operation_o = CSRRSI;
              F3_CSRRCI: operation_o = CSRRCI;
              default:   operation_o = INVALID;
            endcase
          end
        end
      end
      default: operation_o = INVALID;
    endcase
  end

  // Build a 32-bit immediate first, then widen by replicating bit 31.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      IMM_Z: imm32 = {27'b0, instr_i[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm_o     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  assign illegal_o = (operation_o == INVALID);

endmodule

// File: rtl/kamus_decode_queue.sv
// ---------------------------------------------------------------------------
// kamus_decode_queue
// DEPTH-entry FIFO between fetch and execute. Each instruction is decoded as
// it is accepted and stored with its PC; the head entry is presented to
// execute from registered storage (one cycle after the push, no bypass).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : drop every queued entry (reset has priority)
//   instr_valid_i/instr_ready_o, instr_i, pc_i : fetch-side handshake
//   dec_valid_o/dec_ready_i : execute-side handshake
//   operation_o, instr_o, imm_o, pc_o, illegal_o : head entry contents
//   count_o             : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
import omer_pkg::*;

module kamus_decode_queue #(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int MACHINE_MODE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [XLEN-1:0]          pc_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output operation_e               operation_o,
  output instr_decoded_t           instr_o,
  output logic [XLEN-1:0]          imm_o,
  output logic [XLEN-1:0]          pc_o,
  output logic                     illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    operation_e      op;
    instr_decoded_t  fields;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t          entries_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;
  logic            pop;

  operation_e      dec_op;
  instr_decoded_t  dec_fields;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  kamus_decoder #(
    .XLEN         (XLEN),
    .MACHINE_MODE (MACHINE_MODE)
  ) u_decoder (
    .instr_i     (instr_i),
    .operation_o (dec_op),
    .fields_o    (dec_fields),
    .imm_o       (dec_imm),
    .illegal_o   (dec_illegal)
  );

  // Handshake depends only on stored occupancy: no ready/valid through-paths.
  assign instr_ready_o = (count_q < CW'(DEPTH));
  assign dec_valid_o   = (count_q != '0);
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = dec_valid_o && dec_ready_i;

  always_comb begin
    wr_entry         = '0;
    wr_entry.op      = dec_op;
    wr_entry.fields  = dec_fields;
    wr_entry.imm     = dec_imm;
    wr_entry.pc      = pc_i;
    wr_entry.illegal = dec_illegal;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so increment wraps for free.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; stale contents are hidden by the count.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      entries_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head        = entries_q[rd_ptr_q];
  assign operation_o = head.op;
  assign instr_o     = head.fields;
  assign imm_o       = head.imm;
  assign pc_o        = head.pc;
  // Gated so an empty queue never reports a stale illegal entry.
  assign illegal_o   = dec_valid_o && head.illegal;
  assign count_o     = count_q;

endmodule

// File: doc/kamus_decode_queue.md
Name: kamus_decode_queue

Overview:
- Parametrised successor to the combinational instruction decoder. It buffers up to DEPTH fetched instructions, decodes each one as it is enqueued, and presents decoded entries in order to the execute stage over a valid/ready handshake.
- Adds behaviour the combinational decoder lacks:
  - XLEN-wide sign-extended immediate selection with correct B/J/S bit ordering
  - an explicit illegal-instruction flag
  - a PC carried with each entry
  - a pipeline flush
  - optional machine-mode CSR/privileged decoding
- Sits between fetch and execute.

Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 32: PC and immediate width; 32 or 64.
- MACHINE_MODE, 1: 1 = decode MRET/WFI and the machine CSR set; 0 = these are illegal and only CYCLE/TIME/CYCLEH/TIMEH are legal CSRs.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all queued entries.
- instr_valid_i  in  1  fetch offers an instruction.
- instr_ready_o  out  1  queue can accept this cycle.
- instr_i  in  32  raw instruction.
- pc_i  in  XLEN  PC of instr_i.
- dec_valid_o  out  1  head entry valid.
- dec_ready_i  in  1  execute consumes the head.
- operation_o  out  operation_e  decoded operation of the head entry.
- instr_o  out  instr_decoded_t  decoded fields of the head: opcode, rd, func3, rs1, rs2, func7.
- imm_o  out  XLEN  sign-extended immediate of the head.
- pc_o  out  XLEN  PC of the head.
- illegal_o  out  1  head entry decoded as INVALID.
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - read/write pointers and count go to 0.
  - dec_valid_o=0, illegal_o=0, count_o=0, instr_ready_o=1 from the next cycle.
  - Data outputs read the entry at the read pointer and are don't-care while dec_valid_o=0.
  - Reset mid-stream drops all entries; no entry is emitted afterwards.
- Push: occurs when instr_valid_i && instr_ready_o. Decode is combinational at the input. The stored entry is {operation, fields, imm, pc, illegal}.
- Pop: occurs when dec_valid_o && dec_ready_i.
- Handshake signals:
  - instr_ready_o = (count < DEPTH). It does not depend on dec_ready_i, so there is no combinational ready path.
  - dec_valid_o = (count != 0).
  - Outputs are driven from registered storage, with no input-to-output combinational path.
- Latency: an instruction pushed at edge N is visible at the outputs after edge N (one cycle). There is no bypass.
- Simultaneous push and pop (count ≥1 and not full): count is unchanged and both pointers advance.
  - When full, push is blocked even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush: at the edge where flush_i=1, pointers and count are cleared.
  - A push or pop in the same cycle is ignored; flush has priority.
  - rst_i has priority over flush_i.
- Order is strict FIFO. Output fields stay stable while dec_valid_o=1 and dec_ready_i=0.
- Decode rules:
  - instr[1:0] != 2'b11 → INVALID.
  - Unknown opcode or funct3 → INVALID.
  - Branch funct3 010/011 → INVALID.
  - ADD/SUB: SUB only when opcode is register-register (instr[5]=1) and instr[30]=1.
  - Shifts: an immediate shift with instr[25]=1 when XLEN=32 → INVALID.
  - FENCE vs FENCE_I is selected by funct3[0].
  - CSR ops are legal only for supported CSRs.
  - A write to a CSR with csr[11:10]=2'b11 is INVALID. A write means CSRRW, or CSRRS/CSRRC with rs1 != 0.
  - PRIV space: ECALL 0x000, EBREAK 0x001; MRET 0x302 and WFI 0x105 only when MACHINE_MODE=1; all else INVALID.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type, FENCE, CSR: imm_o = zero-extended instr[19:15] for CSR (uimm), else 0.
- illegal_o = (operation == INVALID). Illegal entries still flow through the queue; they are not dropped.

Decomposition:
- Shared package omer_pkg holds:
  - operation_e, instr_decoded_t, csr_e
  - opcode/funct3/funct12 constants
  - an imm_fmt_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_NONE}
- One sub-module, kamus_decoder: combinational, parametrised by XLEN/MACHINE_MODE. It maps instr to {operation, fields, imm, illegal}.
- The queue wrapper instantiates kamus_decoder and holds the storage array plus pointer/count logic.

Test Plan:
- Reset, then push 0x00500093 (ADDI x1,x0,5) at PC 0x100 with dec_ready_i=0:
  - next cycle: dec_valid_o=1, operation_o=ADD, imm_o=5, pc_o=0x100, count_o=1.
- Push BEQ 0xFE000EE3:
  - imm_o=-4 (0xFFFFFFFC); J-type 0xFFDFF0EF gives imm_o=-4; SW 0xFE112E23 gives imm_o=-4.
- Fill DEPTH=4 with dec_ready_i=0:
  - instr_ready_o=0 at count 4; a 5th offer is not accepted.
  - Release dec_ready_i: entries exit in order and pointers wrap over 3 refills.
- Simultaneous push and pop at count=2 for 10 cycles:
  - count_o holds 2 and the output sequence matches the input.
- Illegal cases:
  - 0x00000000 → illegal_o=1.
  - CSRRW to 0xC00 → INVALID.
  - CSRRS to 0xC00 with rs1=0 → CSRRS.
  - MRET with MACHINE_MODE=0 → INVALID; with MACHINE_MODE=1 → MRET.
- Flush with count=3 while pushing and popping in the same cycle:
  - next cycle: count_o=0, dec_valid_o=0, and no pushed entry survives.
  - With rst_i and flush_i both high, the reset values apply.
